nmul_seq: RTL and testbench

Parametrised sequential N-bit × N-bit shift-and-add multiplier with a start/busy/done handshake, the next generation of the team's NMul multiplier. It computes one partial product per clock, so area scales linearly with Nsize while latency is Nsize+1 cycles. The block sits between a requesting datapath (or testbench driver) and any consumer of the 2·Nsize-bit product. An optional signed (two's-complement) mode is selected at compile time.

---
 rtl/nmul_seq.sv | 116 +++++++++++
 tb/tb_nmul_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nmul_seq.sv
// rtl/nmul_seq.sv - sequential Nsize x Nsize shift-and-add multiplier, signed mode under NMUL_SIGNED_EN
module nmul_seq #(
  parameter int Nsize = 4
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic                 Start,
  input  logic [Nsize-1:0]     A,
  input  logic [Nsize-1:0]     B,
`ifdef NMUL_SIGNED_EN
  input  logic                 Sgn,
`endif
  output logic                 Busy,
  output logic                 Done,
  output logic [2*Nsize-1:0]   R
);

  localparam int CW = $clog2(Nsize + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [Nsize-1:0]   mcand_q;
  logic [Nsize-1:0]   mplr_q;
  logic [2*Nsize-1:0] acc_q;
  logic [2*Nsize-1:0] r_q;
  logic [CW-1:0]      cnt_q;

  logic               accept;
  logic               last;
  logic [Nsize-1:0]   a_ld;
  logic [Nsize-1:0]   b_ld;
  logic [2*Nsize-1:0] addend;
  logic [2*Nsize-1:0] acc_sum;
  logic [2*Nsize-1:0] prod_fix;

`ifdef NMUL_SIGNED_EN
  logic               neg_q;
  logic               neg_ld;

  // Operands are loaded as magnitudes; the product sign is remembered for the final fix-up
  always_comb begin
    a_ld     = (Sgn && A[Nsize-1]) ? -A : A;
    b_ld     = (Sgn && B[Nsize-1]) ? -B : B;
    neg_ld   = Sgn && (A[Nsize-1] ^ B[Nsize-1]);
    prod_fix = neg_q ? -acc_sum : acc_sum;
  end
`else
  // Unsigned build: operands pass straight through, no sign fix-up
  always_comb begin
    a_ld     = A;
    b_ld     = B;
    prod_fix = acc_sum;
  end
`endif

  // Partial product for the current multiplier bit and the running sum
  always_comb begin
    accept  = (state_q != RUN) && Start;
    last    = (state_q == RUN) && (cnt_q == CW'(Nsize - 1));
    addend  = mplr_q[0] ? ({{Nsize{1'b0}}, mcand_q} << cnt_q) : '0;
    acc_sum = acc_q + addend;
  end

  // State register; reset dominates everything including Start
  always_ff @(posedge Clk) begin
    if (!Clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: DONE behaves like IDLE for accepting a new request
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = Start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, one multiplier bit per RUN edge, publish on the last bit
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
`ifdef NMUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else if (accept) begin
      mcand_q <= a_ld;
      mplr_q  <= b_ld;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef NMUL_SIGNED_EN
      neg_q   <= neg_ld;
`endif
    end else if (state_q == RUN) begin
      acc_q  <= acc_sum;
      mplr_q <= mplr_q >> 1;
      cnt_q  <= cnt_q + CW'(1);
      if (last) r_q <= prod_fix;
    end
  end

  // Outputs decode straight from registers
  always_comb begin
    Busy = (state_q == RUN);
    Done = (state_q == DONE);
    R    = r_q;
  end

endmodule

// File: tb/tb_nmul_seq.sv
// tb/tb_nmul_seq.sv - directed self-checking bench for nmul_seq (Nsize=4)
module tb_nmul_seq;

  logic       Clk = 1'b0;
  logic       Clr;
  logic       Start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Sgn;
  logic       Busy;
  logic       Done;
  logic [7:0] R;

  int tests_run    = 0;
  int tests_failed = 0;

  nmul_seq #(.Nsize(4)) dut (
    .Clk   (Clk),
    .Clr   (Clr),
    .Start (Start),
    .A     (A),
    .B     (B),
`ifdef NMUL_SIGNED_EN
    .Sgn   (Sgn),
`endif
    .Busy  (Busy),
    .Done  (Done),
    .R     (R)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for Done; lat counts edges after the accepting edge
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic s, output int lat);
    A = a; B = b; Sgn = s; Start = 1'b1;
    tick();
    Start = 1'b0;
    lat = 0;
    while (!Done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int dones;
  int exp_p;

  initial begin
    Clr = 1'b0; Start = 1'b0; A = '0; B = '0; Sgn = 1'b0;

    // Reset and idle
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_r", R, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
    end
    Clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_r", R, 0);
      check("idle_busy", Busy, 0);
      check("idle_done", Done, 0);
    end

    // Directed unsigned vectors
    do_op(4'd15, 4'd15, 1'b0, lat);
    check("u15x15_lat", lat, 4);
    check("u15x15_r", R, 8'hE1);
    check("u15x15_busy", Busy, 0);
    tick();
    check("u15x15_done_drop", Done, 0);
    check("u15x15_hold", R, 8'hE1);
    do_op(4'd0, 4'd9, 1'b0, lat);
    check("u0x9_lat", lat, 4);
    check("u0x9_r", R, 8'h00);
    tick();
    do_op(4'd12, 4'd10, 1'b0, lat);
    check("u12x10_r", R, 8'h78);
    tick();

    // Exhaustive sweep, back-to-back: next Start is raised in each DONE cycle
    A = 4'd0; B = 4'd0; Start = 1'b1;
    tick();
    for (int idx = 0; idx < 256; idx++) begin
      Start = 1'b0;
      lat = 0;
      while (!Done && lat < 20) begin
        tick();
        lat++;
      end
      exp_p = (idx / 16) * (idx % 16);
      check("exh_lat", lat, 4);
      check("exh_r", R, exp_p);
      if (idx < 255) begin
        A = 4'((idx + 1) / 16);
        B = 4'((idx + 1) % 16);
        Start = 1'b1;
        tick();
        check("b2b_busy", Busy, 1);
      end
    end
    tick();
    check("exh_idle", Busy, 0);

    // Busy protection: second request two cycles into a run is ignored
    A = 4'd7; B = 4'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin A = 4'd15; B = 4'd15; Start = 1'b1; end
      if (i == 2) Start = 1'b0;
      tick();
      if (Done) dones++;
    end
    check("busy_dones", dones, 1);
    check("busy_r", R, 8'h15);
    check("busy_idle", Busy, 0);

    // Reset in the second RUN cycle aborts with no Done
    A = 4'd9; B = 4'd9; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    Clr = 1'b0;
    tick();
    Clr = 1'b1;
    check("abort_r", R, 0);
    check("abort_busy", Busy, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (Done || Busy) dones++;
    end
    check("abort_quiet", dones, 0);
    do_op(4'd2, 4'd3, 1'b0, lat);
    check("after_abort_lat", lat, 4);
    check("after_abort_r", R, 8'h06);
    tick();

    // Reset and Start on the same edge: reset wins
    Clr = 1'b0; A = 4'd5; B = 4'd5; Start = 1'b1;
    tick();
    Clr = 1'b1; Start = 1'b0;
    check("clr_start_busy", Busy, 0);
    check("clr_start_r", R, 0);
    tick();
    check("clr_start_busy2", Busy, 0);

`ifdef NMUL_SIGNED_EN
    // Signed vectors
    do_op(4'hD, 4'h5, 1'b1, lat);
    check("s_m3x5", R, 8'hF1);
    tick();
    do_op(4'h8, 4'h8, 1'b1, lat);
    check("s_m8xm8", R, 8'h40);
    tick();
    do_op(4'h7, 4'hF, 1'b1, lat);
    check("s_7xm1", R, 8'hF9);
    tick();
    do_op(4'hF, 4'hF, 1'b0, lat);
    check("s_unsigned_ff", R, 8'hE1);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
